// File: rtl/store_handler.sv
// store_handler: performs SB/SH/SW stores on a word-only memory port.
// Sub-word stores use read-modify-write: read the aligned word, merge the
// byte or halfword into its lane, then write the whole word back.
module store_handler (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_funct3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] word_q, word_d;

    // Unknown funct3 or a halfword/word access off its natural alignment.
    function automatic logic req_rejected(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = off[0];
            F3_SW:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Insert the low byte (SB) or low halfword (SH) of src into lane off of old.
    function automatic logic [31:0] merge_lane(input logic [31:0] old,
                                               input logic [31:0] src,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [31:0] w;
        w = old;
        if (f3 == F3_SH) begin
            if (off[1]) w[31:16] = src[15:0];
            else        w[15:0]  = src[15:0];
        end else begin
            case (off)
                2'd0:    w[7:0]   = src[7:0];
                2'd1:    w[15:8]  = src[7:0];
                2'd2:    w[23:16] = src[7:0];
                default: w[31:24] = src[7:0];
            endcase
        end
        return w;
    endfunction

    // Next-state and register-update logic for the store sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        funct3_d = funct3_q;
        word_d   = word_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_address;
                    data_d   = req_data;
                    funct3_d = req_funct3;
                    if (req_rejected(req_funct3, req_address[1:0])) begin
                        state_d = S_ERROR;
                    end else if (req_funct3 == F3_SW) begin
                        word_d  = req_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    word_d  = merge_lane(mem_rdata, data_q, funct3_q, addr_q[1:0]);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: decoded purely from state and held registers.
    always_comb begin
        req_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        mem_address = {addr_q[31:2], 2'b00};
        mem_wdata   = word_q;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_READ:  mem_req   = 1'b1;
            S_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            funct3_q <= 3'd0;
            word_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            funct3_q <= funct3_d;
            word_q   <= word_d;
        end
    end

endmodule

// File: tb/tb_store_handler.sv
// tb_store_handler: randomized and directed stores against a transaction-level
// model (expected merged word plus a per-phase cycle timeline) and a bench memory.
module tb_store_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_address = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        done;
    logic        error;

    store_handler dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_address (req_address),
        .req_data    (req_data),
        .req_funct3  (req_funct3),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit noise = 1'b0;

    // Current transaction as seen by the model.
    bit          txn_v = 1'b0;
    logic [31:0] t_addr = 32'd0;
    logic [31:0] t_word = 32'd0;
    bit          t_err = 1'b0;
    bit          t_sub = 1'b0;
    int          t_rd = 0;
    int          t_wd = 0;
    int          t_done = 0;
    int          acc_cyc = 0;

    logic [31:0] mem [logic [31:0]];

    logic [31:0] la = 32'd0;
    logic [31:0] lw = 32'd0;
    int last_done_cyc = -100;
    int last_err_cyc = -100;
    int c_s, r_s;
    bit c_busy, r_busy, e_rd, e_wr, e_done, e_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return wa ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_err(input logic [2:0] f, input logic [1:0] off);
        if (f > 3'd2) return 1'b1;
        if (f == 3'd1) return off[0];
        if (f == 3'd2) return off != 2'd0;
        return 1'b0;
    endfunction

    // Byte-array view: overwrite n consecutive bytes starting at lane off.
    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [2:0] f, input logic [1:0] off);
        logic [7:0] b [4];
        int n;
        n = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        for (int i = 0; i < n; i++) b[int'(off) + i] = d[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Compare DUT outputs with the model timeline every cycle.
    always @(posedge clk) begin
        #1;
        c_s    = cyc - acc_cyc;
        c_busy = txn_v && c_s >= 0 && c_s <= t_done;
        e_err  = c_busy && t_err && c_s == 0;
        e_rd   = c_busy && !t_err && t_sub && c_s <= t_rd;
        e_wr   = c_busy && !t_err && (t_sub ? (c_s > t_rd && c_s < t_done) : (c_s < t_done));
        e_done = c_busy && !t_err && c_s == t_done;
        if (reset) begin
            la = 32'd0;
            lw = 32'd0;
        end else if (txn_v && c_s == 0) begin
            la = t_addr;
            if (!t_err && !t_sub) lw = t_word;
        end
        if (!reset && txn_v && !t_err && t_sub && c_s == t_rd + 1) lw = t_word;
        chk("req_ready", 32'(req_ready), 32'(!c_busy));
        chk("mem_req", 32'(mem_req), 32'(e_rd || e_wr));
        chk("done", 32'(done), 32'(e_done));
        chk("error", 32'(error), 32'(e_err));
        chk("mem_address", mem_address, {la[31:2], 2'b00});
        if (e_rd || e_wr || reset) chk("mem_we", 32'(mem_we), 32'(e_wr));
        if (e_wr || !c_busy) chk("mem_wdata", mem_wdata, lw);
        if (done === 1'b1) last_done_cyc = cyc;
        if (error === 1'b1) last_err_cyc = cyc;
    end

    // Memory responder: ack on the modelled last cycle of each phase, random ack noise when idle.
    always @(negedge clk) begin
        r_s    = cyc - acc_cyc;
        r_busy = txn_v && r_s >= 0 && r_s <= t_done && !t_err;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (r_busy && t_sub && r_s == t_rd) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_rd({t_addr[31:2], 2'b00});
        end else if (r_busy && r_s == t_done - 1 && (!t_sub || r_s > t_rd)) begin
            mem_ack = 1'b1;
            mem[{t_addr[31:2], 2'b00}] = mem_wdata;
        end else if (noise && !(r_busy && r_s < t_done)) begin
            mem_ack = 1'($urandom % 2);
        end
    end

    // Called at a negedge; waits for the model to be idle, then presents one request.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                         input int rd, input int wd);
        while (txn_v && (cyc - acc_cyc) <= t_done) begin
            if (noise) begin
                req_valid   = 1'($urandom % 2);
                req_address = $urandom;
                req_data    = $urandom;
                req_funct3  = 3'($urandom);
            end
            @(negedge clk);
        end
        t_addr  = a;
        t_err   = model_err(f, a[1:0]);
        t_sub   = !t_err && f != 3'd2;
        t_rd    = rd;
        t_wd    = wd;
        t_done  = t_err ? 0 : (t_sub ? rd + wd + 2 : wd + 1);
        t_word  = t_err ? 32'd0 : model_merge(mem_rd({a[31:2], 2'b00}), d, f, t_sub ? a[1:0] : 2'b00);
        acc_cyc = cyc + 1;
        txn_v   = 1'b1;
        req_valid   = 1'b1;
        req_address = a;
        req_data    = d;
        req_funct3  = f;
        @(negedge clk);
        req_valid   = 1'b0;
        req_address = $urandom;
        req_data    = $urandom;
        req_funct3  = 3'($urandom);
    endtask

    task automatic wait_idle();
        while (txn_v && (cyc - acc_cyc) <= t_done) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc_pin;
        logic [31:0] a;
        logic [2:0] f;
        int r;

        // A request presented during reset must be ignored.
        req_valid   = 1'b1;
        req_address = 32'h0000_0100;
        req_data    = 32'h1111_2222;
        req_funct3  = 3'b010;
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);

        // SB into lane 1, zero-wait memory.
        mem[32'h0000_1000] = 32'h1122_3344;
        store(32'h0000_1001, 32'hFFFF_FFAB, 3'b000, 0, 0);
        acc_pin = acc_cyc;
        chk("model_sb_word", t_word, 32'h1122_AB44);
        wait_idle();
        chk("sb_mem", mem_rd(32'h0000_1000), 32'h1122_AB44);
        chk("sb_latency", 32'(last_done_cyc - acc_pin), 32'd2);

        // SH upper half, both accesses delayed two cycles.
        mem[32'h0000_2000] = 32'hDEAD_C0DE;
        store(32'h0000_2002, 32'h0000_BEEF, 3'b001, 2, 2);
        acc_pin = acc_cyc;
        chk("model_sh_word", t_word, 32'hBEEF_C0DE);
        wait_idle();
        chk("sh_mem", mem_rd(32'h0000_2000), 32'hBEEF_C0DE);
        chk("sh_latency", 32'(last_done_cyc - acc_pin), 32'd6);

        // SW then back-to-back SB into lane 3 of the same word.
        store(32'h0000_3000, 32'hCAFE_F00D, 3'b010, 0, 0);
        acc1 = acc_cyc;
        wait_idle();
        chk("sw_mem", mem_rd(32'h0000_3000), 32'hCAFE_F00D);
        chk("sw_latency", 32'(last_done_cyc - acc1), 32'd1);
        store(32'h0000_3003, 32'h1234_5655, 3'b000, 0, 0);
        chk("b2b_spacing", 32'(acc_cyc - acc1), 32'd3);
        wait_idle();
        chk("lane3_mem", mem_rd(32'h0000_3000), 32'h55FE_F00D);

        // Rejected requests: misaligned SH, misaligned SW, invalid funct3.
        mem[32'h0000_2000] = 32'h0102_0304;
        store(32'h0000_2001, 32'h0000_FFFF, 3'b001, 0, 0);
        chk("err_sh_latency", 32'(last_err_cyc - acc_cyc), 32'd0);
        wait_idle();
        store(32'h0000_3002, 32'hAAAA_AAAA, 3'b010, 0, 0);
        chk("err_sw_latency", 32'(last_err_cyc - acc_cyc), 32'd0);
        wait_idle();
        store(32'h0000_2000, 32'hBBBB_BBBB, 3'b011, 0, 0);
        chk("err_f3_latency", 32'(last_err_cyc - acc_cyc), 32'd0);
        wait_idle();
        chk("err_mem_2000", mem_rd(32'h0000_2000), 32'h0102_0304);
        chk("err_mem_3000", mem_rd(32'h0000_3000), 32'h55FE_F00D);

        // Reset while READ waits for an ack that never comes.
        last_done_cyc = -100;
        store(32'h0000_5001, 32'h0000_0077, 3'b000, 20, 0);
        @(negedge clk);
        reset = 1'b1;
        txn_v = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", 32'(last_done_cyc), 32'hFFFF_FF9C);
        store(32'h0000_5000, 32'h1234_5678, 3'b010, 1, 1);
        wait_idle();
        chk("sw_after_reset", mem_rd(32'h0000_5000), 32'h1234_5678);

        // Randomized traffic with ack and request noise.
        noise = 1'b1;
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom % 10);
            f = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            a = 32'h0000_4000 + 32'(($urandom % 8) * 4) + 32'($urandom % 4);
            if (f == 3'd2 && ($urandom % 4) != 0) a[1:0] = 2'b00;
            if (f == 3'd1 && ($urandom % 4) != 0) a[0] = 1'b0;
            store(a, $urandom, f, int'($urandom % 4), int'($urandom % 4));
            repeat ($urandom % 3) @(negedge clk);
        end
        noise = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_handler.md
# store_handler

Store-side counterpart to the load datapath: accepts SB/SH/SW requests from the core and performs them on a word-only data memory port that has no byte enables. Sub-word stores use a read-modify-write sequence: read the aligned word, merge the byte or halfword into the correct lane, write the word back. The block sits between the core's store path and the data-memory request/acknowledge port and signals completion so the core can stall until the store finishes.

## Interface
- No parameters; all widths fixed at 32-bit RV32.
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; all state cleared at the rising edge where reset=1
- req_valid  in  1  store request present
- req_ready  out  1  block idle, can accept a request
- req_address  in  32  byte address of store
- req_data  in  32  store source (rs2); low byte/halfword used for SB/SH
- req_funct3  in  3  000 SB, 001 SH, 010 SW; anything else invalid
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read (valid while mem_req=1)
- mem_address  out  32  word-aligned address {req_address[31:2], 2'b00}
- mem_wdata  out  32  word to write
- mem_rdata  in  32  read word, valid in the cycle mem_ack=1 during a read
- mem_ack  in  1  access completes at the rising edge where mem_req & mem_ack
- done  out  1  one-cycle pulse when the store has committed
- error  out  1  one-cycle pulse for a misaligned or invalid request; no memory access occurs

## Operation
- Moore FSM: IDLE, READ, WRITE, DONE, ERROR. All outputs decode from state and from registers only.
- Registers: state, addr_q (32), data_q (32), funct3_q (3), word_q (32, merged write word).
- IDLE: req_ready=1. On req_valid, latch address, data and funct3 into registers, then:
  - invalid funct3, SH with address[0]=1, or SW with address[1:0]≠0 → ERROR
  - SW → WRITE, with word_q=req_data
  - SB or SH → READ
- READ: mem_req=1, mem_we=0. Hold until mem_ack. At the ack edge, load word_q with mem_rdata merged as follows, then go to WRITE:
  - SB, offset k=addr_q[1:0]: replace byte lane k (bits 8k+7:8k) with data_q[7:0]; other bytes unchanged.
  - SH, offset 0: replace [15:0] with data_q[15:0]. SH, offset 2: replace [31:16] with data_q[15:0].
- WRITE: mem_req=1, mem_we=1, mem_wdata=word_q. Hold until mem_ack, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: error=1 for one cycle, then IDLE; mem_req stays 0 throughout.
- mem_address = {addr_q[31:2], 2'b00} in all states. mem_wdata = word_q in all states; it is only meaningful in WRITE.
- req_data[31:16] is ignored for SH; req_data[31:8] is ignored for SB.

## Timing
- Reset values: state=IDLE, addr_q=0, data_q=0, funct3_q=0, word_q=0.
- Outputs from the first edge with reset=1: req_ready=1, mem_req=0, mem_we=0, mem_address=0, mem_wdata=0, done=0, error=0.
- A request is not accepted in any cycle where reset=1.
- Reset mid-operation (READ/WRITE/DONE/ERROR) aborts to IDLE at that edge:
  - mem_req drops in the following cycle.
  - No done or error pulse is produced.
  - A write already acknowledged is not undone.
- Acceptance edge: the rising edge with req_valid & req_ready.
- mem_ack may be asserted in the first cycle of mem_req (zero wait states) or any number of cycles later. While waiting, mem_req, mem_we, mem_address and mem_wdata stay stable.
- Latency from acceptance edge to done high, with zero-wait memory:
  - SW: 2 cycles (WRITE, then DONE).
  - SB/SH: 3 cycles (READ, WRITE, then DONE).
  - Each memory wait state adds one cycle.
- Error path: error is high in the cycle after acceptance.
- req_ready is low from the cycle after acceptance until the cycle after done or error. Minimum back-to-back spacing is 3 cycles for SW and 4 cycles for SB/SH.
- mem_ack is ignored while mem_req=0. req_valid is ignored outside IDLE.

## Test plan
- SB to 0x0000_1001, req_data=0xFFFF_FFAB; memory word 0x1122_3344 with zero-wait ack → READ at 0x0000_1000, then write 0x1122_AB44; done at acceptance+3.
- SH to 0x0000_2002, req_data=0x0000_BEEF; memory 0xDEAD_C0DE; ack delayed 2 cycles on both read and write → write 0xBEEF_C0DE; done at acceptance+7; mem outputs stable while waiting.
- SW to 0x0000_3000, req_data=0xCAFE_F00D → no read; single write of 0xCAFE_F00D; done at acceptance+2. Issue back-to-back with an SB to 0x0000_3003 and check correct lane-3 merge.
- Error cases: SH to 0x0000_2001, SW to 0x0000_3002, and funct3=011 → each gives an error pulse at acceptance+1; mem_req stays 0; req_ready returns at acceptance+2.
- Reset assertion while in READ with ack withheld → next cycle is IDLE with mem_req=0 and no done pulse. A fresh SW then completes normally.
